// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: shares one combinational Q6.10 square-root unit between
// NUM_REQ requesters using round-robin arbitration and a valid/ready
// handshake. The winning operand is registered into stage 1, which drives
// the shared unit. The unit's result is registered into stage 2 and tagged
// with the owning requester id. Fixed 2-cycle latency, one result per cycle.
//
// Optional feature (macro SQRT_ARB_RANGE_FLAG_EN): adds rsp_clamped, which
// flags operands outside [0, 16384]. The shared unit clamps those operands.
module sqrt_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arb_en,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*16-1:0]  req_x,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [15:0]            sqrt_x,
    input  logic [15:0]            sqrt_y,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [15:0]            rsp_sqrt,
`ifdef SQRT_ARB_RANGE_FLAG_EN
    output logic                   rsp_clamped,
`endif
    output logic                   busy
);

    logic [ID_W-1:0]      rr_ptr;
    logic [2*NUM_REQ-1:0] dbl_req;
    logic                 found;
    logic [ID_W-1:0]      win_id;
    logic [15:0]          win_x;
    logic                 hs;

    logic                 s1_valid;
    logic [15:0]          s1_x;
    logic [ID_W-1:0]      s1_id;

`ifdef SQRT_ARB_RANGE_FLAG_EN
    logic                 win_oor;
    logic                 s1_oor;
`endif

    // Round-robin search: rotate the request vector so that index rr_ptr+1
    // lands at bit 0, then take the lowest set bit as the winner.
    always_comb begin
        dbl_req = {req_valid, req_valid} >> ({1'b0, rr_ptr} + 1'b1);
        found   = 1'b0;
        win_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && dbl_req[k]) begin
                found  = 1'b1;
                win_id = ID_W'((int'(rr_ptr) + 1 + k) % NUM_REQ);
            end
        end
    end

    // Operand mux for the winner, plus grant and handshake generation.
    always_comb begin
        win_x = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == win_id) begin
                win_x = req_x[i*16 +: 16];
            end
        end
        hs        = found & arb_en;
        req_ready = hs ? (NUM_REQ'(1) << win_id) : '0;
    end

`ifdef SQRT_ARB_RANGE_FLAG_EN
    // Out-of-range detection on the winning operand (negative or above 16.0).
    always_comb begin
        win_oor = ($signed(win_x) < 16'sd0) || ($signed(win_x) > 16'sd16384);
    end
`endif

    // Round-robin pointer: remembers the last winner so it has lowest priority next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= ID_W'(NUM_REQ - 1);
        end else if (hs) begin
            rr_ptr <= win_id;
        end
    end

    // Stage 1: capture the granted operand and its owner; operand feeds the shared unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_id    <= '0;
`ifdef SQRT_ARB_RANGE_FLAG_EN
            s1_oor   <= 1'b0;
`endif
        end else begin
            s1_valid <= hs;
            if (hs) begin
                s1_x  <= win_x;
                s1_id <= win_id;
`ifdef SQRT_ARB_RANGE_FLAG_EN
                s1_oor <= win_oor;
`endif
            end
        end
    end

    // Stage 2: register the shared unit's result together with the requester tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sqrt  <= '0;
`ifdef SQRT_ARB_RANGE_FLAG_EN
            rsp_clamped <= 1'b0;
`endif
        end else begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_sqrt <= sqrt_y;
                rsp_id   <= s1_id;
`ifdef SQRT_ARB_RANGE_FLAG_EN
                rsp_clamped <= s1_oor;
`endif
            end
        end
    end

    assign sqrt_x = s1_x;
    assign busy   = s1_valid | rsp_valid;

endmodule
